xbar_core_param: RTL and testbench
==================================

Name: xbar_core_param

Overview:
- Parametrised successor of the fixed 3-channel/4-bank request crossbar; routes cache requests from NUM_CH input channels to NUM_BANK bank hit-test units (htu).
- Each channel has one virtual output queue (VOQ) per bank, so a blocked bank does not stall traffic to other banks.
- Each bank has a round-robin arbiter that advances only on a completed handshake.
- Sits between the channel request ports and the bank htu pipelines.

Parameters:
- NUM_CH, 3, number of request channels (>=2).
- NUM_BANK, 4, number of banks (power of two, >=2).
- DEPTH, 2, entries per VOQ (power of two, >=2).
- AW, 32, full address width; the block carries bits [AW-1:4] (line address).
- OP_W, 2, opcode width.
- WBID_W, 8, write-buffer id width, carried through unchanged.
- Derived: LAW=AW-4, CHW=$clog2(NUM_CH), BKW=$clog2(NUM_BANK).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- ch_req_valid_i  in  NUM_CH  per-channel request valid.
- ch_req_ready_o  out  NUM_CH  per-channel accept.
- ch_req_op_i  in  NUM_CH*OP_W  opcode, channel c at [c*OP_W +: OP_W].
- ch_req_addr_i  in  NUM_CH*LAW  line address [AW-1:4], packed per channel.
- ch_req_wbid_i  in  NUM_CH*WBID_W  write-buffer id.
- bank_valid_o  out  NUM_BANK  request valid toward htu.
- bank_ready_i  in  NUM_BANK  htu accept.
- bank_ch_id_o  out  NUM_BANK*CHW  source channel of the presented request.
- bank_op_o  out  NUM_BANK*OP_W  opcode.
- bank_addr_o  out  NUM_BANK*LAW  line address.
- bank_wbid_o  out  NUM_BANK*WBID_W  write-buffer id.
- voq_full_o  out  NUM_CH*NUM_BANK  status: VOQ[c][b] full, bit c*NUM_BANK+b.

Behaviour:
- Bank select: bank = addr[4 +: BKW], i.e. bits [4+BKW-1:4] of the full address, which is bits [BKW-1:0] of ch_req_addr_i for that channel.
- Channel handshake:
  - ch_req_ready_o[c] = !full(VOQ[c][bank(addr_c)]). Combinational on the address only, never on valid.
  - Enqueue when valid&ready.
  - A full VOQ does not accept, even if it dequeues in the same cycle (no full-pass-through).
- VOQ: DEPTH-entry FIFO storing {op, addr, wbid}.
  - Pointers are log2(DEPTH)+1 bits with wrap bit; full/empty from pointer compare.
  - Simultaneous enqueue and dequeue on a non-full, non-empty VOQ leaves the count unchanged.
- Latency: a request accepted at edge t is presentable at a bank from cycle t+1. There is no same-cycle bypass.
- Arbitration, per bank b:
  - Requesters are the !empty(VOQ[c][b]) bits; a one-hot grant is taken from the round-robin pointer.
  - bank_valid_o[b] = any requester.
  - Data and ch_id are muxed from the granted VOQ head.
  - The grant is held stable while valid && !ready: the pointer is frozen and the head cannot change.
  - On bank handshake: dequeue the granted head; the pointer moves to the granted channel +1, mod NUM_CH.
  - With no handshake the pointer holds.
- Ordering:
  - Strict FIFO per (channel, bank).
  - No ordering guarantee across banks, or across channels to the same bank.
- Reset (asynchronous assert, synchronous deassert by the environment):
  - All VOQs empty; all RR pointers = channel 0.
  - bank_valid_o = 0; voq_full_o = 0; ch_req_ready_o = all 1s.
  - Data outputs = 0 while not valid: data is AND-gated with the grant, so idle buses are 0.
  - Reset mid-operation drops all queued entries silently.

Optional Feature:
- Macro XBAR_CORE_OUT_REG_EN.
- Defined: each bank output passes through a 2-entry skid buffer.
  - Bank outputs become registered; latency is t+2.
  - bank_ready_i has no combinational path to the VOQs or arbiter.
  - Throughput is still 1 request/cycle per bank.
  - Reset clears the skid buffers.
- Undefined: outputs are combinational from the VOQ heads, as described in Behaviour.

Decomposition:
- Package xbar_pkg:
  - Request struct type xbar_req_t {op, addr, wbid}.
  - Function bank_sel(addr).
  - Localparams LAW, CHW, BKW.
  - Opcode constants.
- Sub-module xbar_rr_arb:
  - Parameter N.
  - Ports: req, advance (handshake), grant one-hot.
  - Instantiated NUM_BANK times.
- The VOQ FIFO is written inline with a generate loop. The skid buffer is inline under the macro.

Test Plan:
- Reset: hold rst_i=0 with valid on all channels -> bank_valid_o=0, ready=all 1s, all bank data outputs 0; release -> queues empty.
- Single request, ch1, addr line 0x0000_0032 (bits[5:4]=3), op=2, wbid=0x5A, accepted at edge t -> bank_valid_o[3]=1 in cycle t+1 with ch_id=1, op=2, wbid=0x5A.
- Fairness:
  - Stimulus: ch0, ch1, ch2 each hold 2 requests to bank0; bank_ready_i[0]=1.
  - Required: grant order ch0,ch1,ch2,ch0,ch1,ch2, one per cycle.
- Backpressure:
  - Stimulus: bank_ready_i[2]=0 with ch0 streaming to bank2.
  - Required: after DEPTH=2 accepts, ch_req_ready_o[0]=0 for bank2 addresses and voq_full_o[0*4+2]=1.
  - Required: ch0 requests to bank1 are still accepted and delivered.
  - Required: the bank2 grant and data stay stable while stalled.
- Wrap and concurrency:
  - Stimulus: 10 back-to-back ch2 requests to bank1 with ready toggling 1,0,1,0.
  - Required: delivered in order with no loss or duplication; pointers wrap.
  - Required: simultaneous enqueue and dequeue keeps occupancy.
- XBAR_CORE_OUT_REG_EN:
  - Stimulus: repeat the single-request test.
  - Required: valid appears at t+2.
  - Required: with ready held at 1, sustained 1 request/cycle per bank.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the request crossbar.
// Default-geometry request struct, bank select helper and opcode constants.
package xbar_pkg;

    localparam int LAW = 28;
    localparam int CHW = 2;
    localparam int BKW = 2;
    localparam int OPW = 2;
    localparam int WBW = 8;

    localparam logic [OPW-1:0] OP_RD  = 2'd0;
    localparam logic [OPW-1:0] OP_WR  = 2'd1;
    localparam logic [OPW-1:0] OP_RDX = 2'd2;
    localparam logic [OPW-1:0] OP_WB  = 2'd3;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [LAW-1:0] addr;
        logic [WBW-1:0] wbid;
    } xbar_req_t;

    // Line address bits [bkw-1:0] pick the bank (full address bits [4+bkw-1:4]).
    function automatic logic [31:0] bank_sel(
        input logic [31:0] line_addr,
        input int          bkw
    );
        return line_addr & ((32'd1 << bkw) - 32'd1);
    endfunction

endpackage

// File: rtl/xbar_core_param_rr_arb.sv
// Round-robin arbiter with grant lock while the winner is not consumed.
// Ports: clk, rst_n, req[N], advance (handshake), grant[N] one-hot.
module xbar_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] held_idx;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  held;
    logic          locked;
    logic          found;

    always_comb begin
        rr_grant = '0;
        rr_idx   = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                rr_grant[(int'(ptr) + i) % N] = 1'b1;
                rr_idx = IW'((int'(ptr) + i) % N);
            end
        end
    end

    // A presented but unconsumed winner stays granted even if a
    // channel nearer the pointer starts requesting.
    assign grant   = locked ? held : rr_grant;
    assign sel_idx = locked ? held_idx : rr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            locked   <= 1'b0;
            held     <= '0;
            held_idx <= '0;
        end else begin
            if (advance) begin
                ptr <= (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;
            end
            locked   <= (|req) && !advance;
            held     <= grant;
            held_idx <= sel_idx;
        end
    end

endmodule

// File: rtl/xbar_core_param.sv
// NUM_CH x NUM_BANK request crossbar: per-(channel,bank) VOQs, RR arbiter per bank.
// Ports: ch_req_* (channel side), bank_* (htu side), voq_full_o status.
// Optional XBAR_CORE_OUT_REG_EN: 2-entry skid buffer on every bank output.
module xbar_core_param
    import xbar_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int NUM_BANK = 4,
    parameter int DEPTH    = 2,
    parameter int AW       = 32,
    parameter int OP_W     = 2,
    parameter int WBID_W   = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_CH-1:0]                      ch_req_valid_i,
    output logic [NUM_CH-1:0]                      ch_req_ready_o,
    input  logic [NUM_CH*OP_W-1:0]                 ch_req_op_i,
    input  logic [NUM_CH*(AW-4)-1:0]               ch_req_addr_i,
    input  logic [NUM_CH*WBID_W-1:0]               ch_req_wbid_i,
    output logic [NUM_BANK-1:0]                    bank_valid_o,
    input  logic [NUM_BANK-1:0]                    bank_ready_i,
    output logic [NUM_BANK*$clog2(NUM_CH)-1:0]     bank_ch_id_o,
    output logic [NUM_BANK*OP_W-1:0]               bank_op_o,
    output logic [NUM_BANK*(AW-4)-1:0]             bank_addr_o,
    output logic [NUM_BANK*WBID_W-1:0]             bank_wbid_o,
    output logic [NUM_CH*NUM_BANK-1:0]             voq_full_o
);

    localparam int L_LAW = AW - 4;
    localparam int L_CHW = $clog2(NUM_CH);
    localparam int L_BKW = $clog2(NUM_BANK);
    localparam int PW    = $clog2(DEPTH);
    localparam int DW    = OP_W + L_LAW + WBID_W;
    localparam int EW    = L_CHW + DW;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [L_LAW-1:0]  addr;
        logic [WBID_W-1:0] wbid;
    } req_t;

    req_t                ch_req  [NUM_CH];
    logic [L_BKW-1:0]    ch_bank [NUM_CH];
    logic [NUM_BANK-1:0] ch_full [NUM_CH];
    logic [DW-1:0]       head    [NUM_CH][NUM_BANK];
    logic [NUM_CH-1:0]   req_v   [NUM_BANK];
    logic [NUM_CH-1:0]   grant   [NUM_BANK];
    logic [NUM_BANK-1:0] adv;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_req[c].op   = ch_req_op_i[c*OP_W +: OP_W];
        assign ch_req[c].addr = ch_req_addr_i[c*L_LAW +: L_LAW];
        assign ch_req[c].wbid = ch_req_wbid_i[c*WBID_W +: WBID_W];
        assign ch_bank[c] = L_BKW'(bank_sel(32'(ch_req[c].addr), L_BKW));
        // Ready looks only at the addressed VOQ, never at valid.
        assign ch_req_ready_o[c] = !ch_full[c][ch_bank[c]];

        for (genvar b = 0; b < NUM_BANK; b++) begin : g_voq
            logic [DW-1:0] mem [DEPTH];
            logic [PW:0]   wp;
            logic [PW:0]   rp;
            logic          enq;
            logic          deq;
            logic          full;
            logic          empty;

            assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
            assign empty = (wp == rp);
            assign enq   = ch_req_valid_i[c] && ch_req_ready_o[c]
                           && (ch_bank[c] == L_BKW'(b));
            assign deq   = adv[b] && grant[b][c];

            assign ch_full[c][b]               = full;
            assign voq_full_o[c*NUM_BANK + b]  = full;
            assign req_v[b][c]                 = !empty;
            assign head[c][b]                  = mem[rp[PW-1:0]];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    wp <= '0;
                    rp <= '0;
                end else begin
                    if (enq) wp <= wp + 1'b1;
                    if (deq) rp <= rp + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (enq) mem[wp[PW-1:0]] <= ch_req[c];
            end
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [DW-1:0]    sel_d;
        logic [L_CHW-1:0] sel_c;
        logic [EW-1:0]    out_e;
        req_t             out_r;

        xbar_rr_arb #(.N(NUM_CH)) u_arb (
            .clk     (clk_i),
            .rst_n   (rst_i),
            .req     (req_v[b]),
            .advance (adv[b]),
            .grant   (grant[b])
        );

        // AND-OR mux: idle buses read as zero.
        always_comb begin
            sel_d = '0;
            sel_c = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sel_d = sel_d | (head[c][b] & {DW{grant[b][c]}});
                if (grant[b][c]) sel_c = sel_c | L_CHW'(c);
            end
        end

`ifdef XBAR_CORE_OUT_REG_EN
        logic [1:0]    cnt;
        logic [EW-1:0] e0;
        logic [EW-1:0] e1;
        logic          push;
        logic          pop;

        // Upstream side sees only the registered occupancy.
        assign adv[b]          = (|req_v[b]) && (cnt != 2'd2);
        assign push            = adv[b];
        assign pop             = (cnt != 2'd0) && bank_ready_i[b];
        assign bank_valid_o[b] = (cnt != 2'd0);
        assign out_e           = e0 & {EW{bank_valid_o[b]}};

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt <= '0;
                e0  <= '0;
                e1  <= '0;
            end else begin
                unique case ({push, pop})
                    2'b10: begin
                        if (cnt == 2'd0) e0 <= {sel_c, sel_d};
                        else             e1 <= {sel_c, sel_d};
                        cnt <= cnt + 2'd1;
                    end
                    2'b01: begin
                        e0  <= e1;
                        e1  <= '0;
                        cnt <= cnt - 2'd1;
                    end
                    2'b11: begin
                        // push implies cnt<2 and pop implies cnt>0
                        e0 <= {sel_c, sel_d};
                    end
                    default: ;
                endcase
            end
        end
`else
        assign bank_valid_o[b] = |req_v[b];
        assign adv[b]          = bank_valid_o[b] && bank_ready_i[b];
        assign out_e           = {sel_c, sel_d};
`endif

        assign out_r = req_t'(out_e[DW-1:0]);
        assign bank_ch_id_o[b*L_CHW +: L_CHW]  = out_e[EW-1:DW];
        assign bank_op_o[b*OP_W +: OP_W]       = out_r.op;
        assign bank_addr_o[b*L_LAW +: L_LAW]   = out_r.addr;
        assign bank_wbid_o[b*WBID_W +: WBID_W] = out_r.wbid;
    end

endmodule

// File: tb/tb_xbar_core_param.sv
// Directed bench for xbar_core_param (default 3 ch, 4 banks, depth 2).
// Latency and capacity expectations follow XBAR_CORE_OUT_REG_EN.
module tb_xbar_core_param;

`ifdef XBAR_CORE_OUT_REG_EN
    localparam int LAT = 2;
    localparam int CAP = 4;
`else
    localparam int LAT = 1;
    localparam int CAP = 2;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  ch_req_valid_i;
    logic [2:0]  ch_req_ready_o;
    logic [5:0]  ch_req_op_i;
    logic [83:0] ch_req_addr_i;
    logic [23:0] ch_req_wbid_i;
    logic [3:0]  bank_valid_o;
    logic [3:0]  bank_ready_i;
    logic [7:0]  bank_ch_id_o;
    logic [7:0]  bank_op_o;
    logic [111:0] bank_addr_o;
    logic [31:0] bank_wbid_o;
    logic [11:0] voq_full_o;

    int n_vec = 0;
    int n_err = 0;

    xbar_core_param dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ch_req_valid_i (ch_req_valid_i),
        .ch_req_ready_o (ch_req_ready_o),
        .ch_req_op_i    (ch_req_op_i),
        .ch_req_addr_i  (ch_req_addr_i),
        .ch_req_wbid_i  (ch_req_wbid_i),
        .bank_valid_o   (bank_valid_o),
        .bank_ready_i   (bank_ready_i),
        .bank_ch_id_o   (bank_ch_id_o),
        .bank_op_o      (bank_op_o),
        .bank_addr_o    (bank_addr_o),
        .bank_wbid_o    (bank_wbid_o),
        .voq_full_o     (voq_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [1:0] op,
                         input logic [27:0] addr, input logic [7:0] wbid);
        ch_req_valid_i[c]        = v;
        ch_req_op_i[c*2 +: 2]    = op;
        ch_req_addr_i[c*28 +: 28] = addr;
        ch_req_wbid_i[c*8 +: 8]  = wbid;
        #1;
    endtask

    int sent;
    int rcvd;
    logic acc;

    initial begin
        rst_i          = 1'b0;
        bank_ready_i   = 4'hF;
        ch_req_valid_i = '0;
        ch_req_op_i    = '0;
        ch_req_addr_i  = '0;
        ch_req_wbid_i  = '0;

        // reset with valid asserted everywhere
        for (int c = 0; c < 3; c++) drive(c, 1'b1, 2'd3, 28'(c), 8'hFF);
        repeat (3) tick();
        chk("rst_valid", 128'(bank_valid_o), 128'h0);
        chk("rst_ready", 128'(ch_req_ready_o), 128'h7);
        chk("rst_full", 128'(voq_full_o), 128'h0);
        chk("rst_chid", 128'(bank_ch_id_o), 128'h0);
        chk("rst_op", 128'(bank_op_o), 128'h0);
        chk("rst_addr", 128'(bank_addr_o), 128'h0);
        chk("rst_wbid", 128'(bank_wbid_o), 128'h0);
        for (int c = 0; c < 3; c++) drive(c, 1'b0, 2'd0, 28'h0, 8'h0);
        rst_i = 1'b1;
        tick();
        chk("post_rst_valid", 128'(bank_valid_o), 128'h0);

        // single request ch1 -> bank3
        drive(1, 1'b1, 2'd2, 28'h3, 8'h5A);
        chk("single_ready", 128'(ch_req_ready_o[1]), 128'h1);
        chk("single_nobypass", 128'(bank_valid_o), 128'h0);
        tick();
        drive(1, 1'b0, 2'd0, 28'h0, 8'h0);
        for (int i = 0; i < LAT - 1; i++) begin
            chk("single_early", 128'(bank_valid_o), 128'h0);
            tick();
        end
        chk("single_valid", 128'(bank_valid_o), 128'h8);
        chk("single_chid", 128'(bank_ch_id_o[6 +: 2]), 128'h1);
        chk("single_op", 128'(bank_op_o[6 +: 2]), 128'h2);
        chk("single_wbid", 128'(bank_wbid_o[24 +: 8]), 128'h5A);
        chk("single_addr", 128'(bank_addr_o[84 +: 28]), 128'h3);
        tick();
        chk("single_done", 128'(bank_valid_o), 128'h0);
        chk("single_idle_wbid", 128'(bank_wbid_o), 128'h0);

        // fairness on bank0
        bank_ready_i[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++)
                drive(c, 1'b1, 2'(k), 28'((c << 8) | (k << 4)),
                      8'(c * 16 + k));
            tick();
        end
        for (int c = 0; c < 3; c++) ch_req_valid_i[c] = 1'b0;
        tick();
        tick();
`ifndef XBAR_CORE_OUT_REG_EN
        chk("fair_full", 128'(voq_full_o), 128'h111);
        chk("fair_ready", 128'(ch_req_ready_o), 128'h0);
`endif
        chk("fair_stall_chid", 128'(bank_ch_id_o[1:0]), 128'h0);
        bank_ready_i[0] = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("fair_valid", 128'(bank_valid_o[0]), 128'h1);
            chk("fair_chid", 128'(bank_ch_id_o[1:0]), 128'(i % 3));
            chk("fair_wbid", 128'(bank_wbid_o[7:0]),
                128'((i % 3) * 16 + i / 3));
            tick();
        end
        chk("fair_drained", 128'(bank_valid_o[0]), 128'h0);

        // backpressure on bank2, ch0 streaming
        bank_ready_i = 4'b1011;
        for (int i = 0; i < CAP; i++) begin
            drive(0, 1'b1, 2'd1, 28'(2 + (i << 4)), 8'(8'hA0 + i));
            chk("bp_accept", 128'(ch_req_ready_o[0]), 128'h1);
            tick();
        end
        drive(0, 1'b1, 2'd1, 28'(2 + (CAP << 4)), 8'(8'hA0 + CAP));
        chk("bp_blocked", 128'(ch_req_ready_o[0]), 128'h0);
        chk("bp_full", 128'(voq_full_o[2]), 128'h1);
        tick();
        chk("bp_valid", 128'(bank_valid_o[2]), 128'h1);
        chk("bp_chid", 128'(bank_ch_id_o[4 +: 2]), 128'h0);
        chk("bp_wbid", 128'(bank_wbid_o[16 +: 8]), 128'hA0);
        chk("bp_addr", 128'(bank_addr_o[56 +: 28]), 128'h2);
        tick();
        tick();
        chk("bp_stable_wbid", 128'(bank_wbid_o[16 +: 8]), 128'hA0);
        chk("bp_stable_addr", 128'(bank_addr_o[56 +: 28]), 128'h2);
        drive(0, 1'b1, 2'd1, 28'h51, 8'hB1);
        chk("bp_other_ready", 128'(ch_req_ready_o[0]), 128'h1);
        tick();
        drive(0, 1'b0, 2'd0, 28'h0, 8'h0);
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("bp_b1_valid", 128'(bank_valid_o[1]), 128'h1);
        chk("bp_b1_wbid", 128'(bank_wbid_o[8 +: 8]), 128'hB1);
        chk("bp_b1_chid", 128'(bank_ch_id_o[2 +: 2]), 128'h0);
        tick();
        chk("bp_b2_held", 128'(bank_wbid_o[16 +: 8]), 128'hA0);
        bank_ready_i[2] = 1'b1;
        #1;
        for (int i = 0; i < CAP; i++) begin
            chk("bp_drain_valid", 128'(bank_valid_o[2]), 128'h1);
            chk("bp_drain_wbid", 128'(bank_wbid_o[16 +: 8]),
                128'(8'hA0 + i));
            tick();
        end
        chk("bp_drained", 128'(bank_valid_o), 128'h0);

        // wrap: 10 requests ch2 -> bank1, ready toggling
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bank_ready_i[1] = (cyc % 2 == 0);
            drive(2, sent < 10, 2'd0, 28'(1 + (sent << 4)),
                  8'(8'hC0 + sent));
            acc = ch_req_valid_i[2] && ch_req_ready_o[2];
            if (bank_valid_o[1] && bank_ready_i[1]) begin
                chk("wrap_chid", 128'(bank_ch_id_o[2 +: 2]), 128'h2);
                chk("wrap_wbid", 128'(bank_wbid_o[8 +: 8]),
                    128'(8'hC0 + rcvd));
                rcvd++;
            end
            tick();
            if (acc) sent++;
        end
        chk("wrap_count", 128'(rcvd), 128'd10);
        chk("wrap_empty", 128'(bank_valid_o), 128'h0);
        bank_ready_i = 4'hF;

        // sustained throughput on bank0 and bank3
        for (int k = 0; k < 6 + LAT; k++) begin
            drive(0, k < 6, 2'd1, 28'(k << 4), 8'(8'hD0 + k));
            drive(1, k < 6, 2'd2, 28'(3 + (k << 4)), 8'(8'hE0 + k));
            if (k < 6)
                chk("tp_ready", 128'(ch_req_ready_o[1:0]), 128'h3);
            if (k >= LAT) begin
                chk("tp_b0", 128'({bank_valid_o[0], bank_wbid_o[7:0]}),
                    128'({1'b1, 8'(8'hD0 + k - LAT)}));
                chk("tp_b3", 128'({bank_valid_o[3], bank_wbid_o[31:24]}),
                    128'({1'b1, 8'(8'hE0 + k - LAT)}));
            end
            tick();
        end
        chk("tp_done", 128'(bank_valid_o), 128'h0);

        // reset mid-operation drops queued entries
        bank_ready_i = 4'h0;
        drive(0, 1'b1, 2'd0, 28'h2, 8'h77);
        tick();
        drive(0, 1'b0, 2'd0, 28'h0, 8'h0);
        tick();
        chk("mid_valid", 128'(bank_valid_o[2]), 128'h1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bank_valid_o), 128'h0);
        chk("mid_rst_wbid", 128'(bank_wbid_o), 128'h0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("mid_after", 128'(bank_valid_o), 128'h0);
        chk("mid_full", 128'(voq_full_o), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
